// File: rtl/chiplet_types_pkg.sv
// Shared flit and endpoint types for the chiplet switch fabric.
// Holds the link flit layout, TX FSM states and RX depth default.
package chiplet_types_pkg;

   localparam int FLIT_VC_W = 4;
   localparam int FLIT_DATA_W = 32;
   localparam int ENDPOINT_RX_DEPTH = 4;

   typedef struct packed {
      logic [FLIT_VC_W-1:0] vc;
      logic [3:0]           dest;
      logic                 head;
      logic                 tail;
   } flit_meta_t;

   typedef struct packed {
      flit_meta_t             metadata;
      logic [FLIT_DATA_W-1:0] data;
   } flit_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } endpoint_tx_state_t;

endpackage

// File: rtl/endpoint_rx_fifo.sv
// Per-VC synchronous receive FIFO for the switch endpoint.
// Push and pop in the same cycle are allowed, including when full.
module endpoint_rx_fifo
   import chiplet_types_pkg::*;
#(
   parameter int DEPTH = ENDPOINT_RX_DEPTH,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  flit_t wdata_i,
   input  logic  pop_i,
   output flit_t rdata_o,
   output logic  full_o,
   output logic  empty_o
);

   flit_t          mem_q [DEPTH];
   logic [AW-1:0]  wp_q;
   logic [AW-1:0]  rp_q;
   logic [AW:0]    cnt_q;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rp_q];

   // Storage array; contents need no reset, occupancy tracks validity.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wp_q] <= wdata_i;
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wp_q <= wp_q + 1'b1;
         if (pop_i)  rp_q <= rp_q + 1'b1;
         if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
         else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/switch_endpoint_link.sv
// Endpoint side of one switch port: credit-gated wormhole TX, per-VC RX.
// Optional SWITCH_ENDPOINT_ERR_EN adds the err_sticky_o error port.
module switch_endpoint_link
   import chiplet_types_pkg::*;
#(
   parameter int NUM_VCS = 2,
   parameter int BUFFER_SIZE = 8,
   parameter int RX_DEPTH = ENDPOINT_RX_DEPTH,
   localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   input  flit_t              tx_flit_i,
   input  logic [VCW-1:0]     tx_vc_i,
   input  logic               tx_last_i,
   output flit_t              link_out_o,
   output logic               link_out_valid_o,
   input  logic [NUM_VCS-1:0] link_credit_ret_i,
   input  flit_t              link_in_i,
   input  logic               link_in_valid_i,
   output logic               link_in_ack_o,
   output logic [NUM_VCS-1:0] link_credit_grant_o,
`ifdef SWITCH_ENDPOINT_ERR_EN
   output logic [2:0]         err_sticky_o,
`endif
   output logic               rx_valid_o,
   input  logic               rx_ready_i,
   output flit_t              rx_flit_o
);

   localparam int CW = $clog2(BUFFER_SIZE + 1);
   localparam logic [VCW:0]   NV_W = (VCW+1)'(NUM_VCS);
   localparam logic [VCW-1:0] LAST_VC = VCW'(NUM_VCS - 1);
   localparam logic [CW-1:0]  CMAX = CW'(BUFFER_SIZE);

   endpoint_tx_state_t state_q, state_d;
   logic [VCW-1:0]     lock_q, lock_d;
   logic [VCW-1:0]     vc_req, vc_sel;
   logic               vc_oor;
   logic               fire;
   logic [CW-1:0]      cred_q [NUM_VCS];
   logic [CW-1:0]      cred_d [NUM_VCS];
   logic [NUM_VCS-1:0] dec_v, max_v;
   flit_t              tx_mod;
   flit_t              link_out_q;
   logic               link_out_valid_q;

   logic [NUM_VCS-1:0] push, pop, full, empty;
   flit_t              rdata [NUM_VCS];
   logic [VCW-1:0]     rr_q, rr_d, rx_sel;
   logic               rx_any;
   logic               ack_q;
   logic [NUM_VCS-1:0] grant_q;

   // Out-of-range VC requests are clamped to the highest VC.
   always_comb begin
      vc_oor = ({1'b0, tx_vc_i} >= NV_W);
      vc_req = vc_oor ? LAST_VC : tx_vc_i;
   end

   // TX FSM: lock the head flit's VC until the tail fires.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      vc_sel  = (state_q == IDLE) ? vc_req : lock_q;
      tx_ready_o = !rst_i && (cred_q[vc_sel] != '0);
      fire = tx_valid_i && tx_ready_o;
      tx_mod = tx_flit_i;
      tx_mod.metadata.vc = FLIT_VC_W'(vc_sel);
      case (state_q)
         IDLE: if (fire && !tx_last_i) begin
            state_d = SEND;
            lock_d  = vc_sel;
         end
         SEND: if (fire && tx_last_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-VC credit next state: fire and return in one cycle cancel.
   always_comb begin
      dec_v = '0;
      max_v = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         dec_v[v] = fire && (vc_sel == VCW'(v));
         max_v[v] = (cred_q[v] == CMAX);
         cred_d[v] = cred_q[v];
         if (dec_v[v] && !link_credit_ret_i[v])
            cred_d[v] = cred_q[v] - 1'b1;
         else if (link_credit_ret_i[v] && !dec_v[v] && !max_v[v])
            cred_d[v] = cred_q[v] + 1'b1;
      end
   end

   // TX state, credits and registered link output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         lock_q  <= '0;
         for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= CMAX;
         link_out_q <= '0;
         link_out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= cred_d[v];
         if (fire) link_out_q <= tx_mod;
         link_out_valid_q <= fire;
      end
   end

   assign link_out_o = link_out_q;
   assign link_out_valid_o = link_out_valid_q;

   for (genvar g = 0; g < NUM_VCS; g++) begin : g_rx
      endpoint_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push[g]),
         .wdata_i (link_in_i),
         .pop_i   (pop[g]),
         .rdata_o (rdata[g]),
         .full_o  (full[g]),
         .empty_o (empty[g])
      );
   end

   // Round-robin pick of the first non-empty VC at or after rr_q.
   always_comb begin
      rx_any = 1'b0;
      rx_sel = rr_q;
      for (int i = 0; i < NUM_VCS; i++) begin
         int idx;
         idx = (int'(rr_q) + i) % NUM_VCS;
         if (!rx_any && !empty[idx]) begin
            rx_any = 1'b1;
            rx_sel = VCW'(idx);
         end
      end
      rx_valid_o = rx_any;
      rx_flit_o  = rdata[rx_sel];
      pop = '0;
      if (rx_any && rx_ready_i) pop[rx_sel] = 1'b1;
      rr_d = rr_q;
      if (rx_any && rx_ready_i)
         rr_d = (rx_sel == LAST_VC) ? '0 : rx_sel + 1'b1;
   end

   // Route incoming flits; a pop on the same FIFO frees a slot first.
   always_comb begin
      push = '0;
      for (int v = 0; v < NUM_VCS; v++)
         push[v] = link_in_valid_i
                && (link_in_i.metadata.vc == FLIT_VC_W'(v))
                && (!full[v] || pop[v]);
   end

   // RX arbiter pointer, store ack and credit grant strobes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q    <= '0;
         ack_q   <= 1'b0;
         grant_q <= '0;
      end else begin
         rr_q    <= rr_d;
         ack_q   <= |push;
         grant_q <= pop;
      end
   end

   assign link_in_ack_o = ack_q;
   assign link_credit_grant_o = grant_q;

`ifdef SWITCH_ENDPOINT_ERR_EN
   logic [2:0] err_q;
   logic       rx_ovf, cred_ovf, oor_ev;

   // Error events: dropped RX flit, credit return at max, bad head VC.
   always_comb begin
      rx_ovf   = link_in_valid_i && !(|push);
      cred_ovf = |(link_credit_ret_i & ~dec_v & max_v);
      oor_ev   = fire && (state_q == IDLE) && vc_oor;
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= '0;
      else       err_q <= err_q | {rx_ovf, cred_ovf, oor_ev};
   end

   assign err_sticky_o = err_q;
`endif

endmodule

// File: tb/tb_switch_endpoint_link.sv
// Randomised self-checking bench for switch_endpoint_link.
// Queue/array reference model of credits, VC lock and RX FIFOs.
module tb_switch_endpoint_link;
   import chiplet_types_pkg::*;

   localparam int NV = 2;
   localparam int BUF = 8;
   localparam int RXD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          tx_valid, tx_ready, tx_last;
   flit_t         tx_flit, link_out, link_in, rx_flit;
   logic [0:0]    tx_vc;
   logic          link_out_valid, link_in_valid, link_in_ack;
   logic [NV-1:0] link_credit_ret, link_credit_grant;
   logic          rx_valid, rx_ready;
`ifdef SWITCH_ENDPOINT_ERR_EN
   logic [2:0]    err_sticky;
`endif

   always #5 clk = ~clk;

   switch_endpoint_link #(
      .NUM_VCS(NV), .BUFFER_SIZE(BUF), .RX_DEPTH(RXD)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .tx_valid_i          (tx_valid),
      .tx_ready_o          (tx_ready),
      .tx_flit_i           (tx_flit),
      .tx_vc_i             (tx_vc),
      .tx_last_i           (tx_last),
      .link_out_o          (link_out),
      .link_out_valid_o    (link_out_valid),
      .link_credit_ret_i   (link_credit_ret),
      .link_in_i           (link_in),
      .link_in_valid_i     (link_in_valid),
      .link_in_ack_o       (link_in_ack),
      .link_credit_grant_o (link_credit_grant),
`ifdef SWITCH_ENDPOINT_ERR_EN
      .err_sticky_o        (err_sticky),
`endif
      .rx_valid_o          (rx_valid),
      .rx_ready_i          (rx_ready),
      .rx_flit_o           (rx_flit)
   );

   int    checks = 0;
   int    passed = 0;
   int    mcred [NV];
   bit    in_pkt;
   int    lock_vc;
   flit_t rq [NV][$];
   int    mrr;

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         mcred[v] = BUF;
         rq[v].delete();
      end
      in_pkt = 0;
      lock_vc = 0;
      mrr = 0;
   endtask

   task automatic idle_inputs();
      tx_valid = 0; tx_vc = 0; tx_last = 0; tx_flit = '0;
      link_credit_ret = '0; link_in = '0; link_in_valid = 0;
      rx_ready = 0;
   endtask

   // One TX cycle: drive, check ready against the model, check output.
   task automatic tx_step(input bit v, input int vc, input bit last,
                          input logic [NV-1:0] ret);
      flit_t f;
      int    evc;
      bit    erdy, fire;
      f = flit_t'({$urandom, $urandom});
      tx_valid = v; tx_vc = 1'(vc); tx_last = last;
      tx_flit = f; link_credit_ret = ret;
      #1;
      evc = in_pkt ? lock_vc : vc;
      erdy = (mcred[evc] != 0);
      fire = v && erdy;
      checks++;
      if (tx_ready !== erdy)
         $display("FAIL tx_ready got %0b exp %0b", tx_ready, erdy);
      else passed++;
      @(posedge clk); #1;
      for (int i = 0; i < NV; i++) begin
         bit d;
         d = fire && (evc == i);
         if (d && !ret[i]) mcred[i]--;
         else if (ret[i] && !d && mcred[i] < BUF) mcred[i]++;
      end
      if (fire) begin
         if (!in_pkt && !last) begin
            in_pkt = 1; lock_vc = evc;
         end else if (in_pkt && last) in_pkt = 0;
      end
      checks++;
      if (link_out_valid !== fire)
         $display("FAIL link_out_valid got %0b exp %0b", link_out_valid, fire);
      else passed++;
      if (fire) begin
         checks++;
         if (link_out.data !== f.data || link_out.metadata.vc !== 4'(evc))
            $display("FAIL link_out got %0h/vc%0d exp %0h/vc%0d",
                     link_out.data, link_out.metadata.vc, f.data, evc);
         else passed++;
      end
      tx_valid = 0; link_credit_ret = '0;
   endtask

   // One RX cycle: drive egress flit and consumer ready, check vs queues.
   task automatic rx_step(input bit iv, input int ivc, input bit rdy);
      flit_t f;
      bit    ev, pop, acc;
      int    sel;
      logic [NV-1:0] eg;
      f = flit_t'({$urandom, $urandom});
      f.metadata.vc = 4'(ivc);
      link_in = f; link_in_valid = iv; rx_ready = rdy;
      #1;
      ev = 0; sel = mrr;
      for (int i = 0; i < NV; i++) begin
         int idx;
         idx = (mrr + i) % NV;
         if (!ev && rq[idx].size() > 0) begin
            ev = 1; sel = idx;
         end
      end
      checks++;
      if (rx_valid !== ev)
         $display("FAIL rx_valid got %0b exp %0b", rx_valid, ev);
      else passed++;
      if (ev) begin
         checks++;
         if (rx_flit !== rq[sel][0])
            $display("FAIL rx_flit got %0h exp %0h", rx_flit, rq[sel][0]);
         else passed++;
      end
      pop = ev && rdy;
      acc = iv && (rq[ivc].size() < RXD || (pop && sel == ivc));
      @(posedge clk); #1;
      eg = '0;
      if (pop) begin
         void'(rq[sel].pop_front());
         mrr = (sel + 1) % NV;
         eg[sel] = 1'b1;
      end
      if (acc) rq[ivc].push_back(f);
      checks++;
      if (link_in_ack !== acc)
         $display("FAIL link_in_ack got %0b exp %0b", link_in_ack, acc);
      else passed++;
      checks++;
      if (link_credit_grant !== eg)
         $display("FAIL credit_grant got %b exp %b", link_credit_grant, eg);
      else passed++;
      link_in_valid = 0; rx_ready = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({link_out_valid, link_out, link_in_ack, link_credit_grant,
           rx_valid, tx_ready} !== '0)
         $display("FAIL reset_outputs got %0b/%0h/%0b/%b/%0b/%0b exp 0",
                  link_out_valid, link_out, link_in_ack,
                  link_credit_grant, rx_valid, tx_ready);
      else passed++;
      checks++;
      if (dut.cred_q[0] !== 4'd8 || dut.cred_q[1] !== 4'd8)
         $display("FAIL reset_credits got %0d/%0d exp 8/8",
                  dut.cred_q[0], dut.cred_q[1]);
      else passed++;
`ifdef SWITCH_ENDPOINT_ERR_EN
      checks++;
      if (err_sticky !== 3'b000)
         $display("FAIL reset_err got %b exp 000", err_sticky);
      else passed++;
`endif
      rst = 0;
   endtask

   task automatic test_credit_exhaust();
      for (int i = 0; i < BUF; i++) tx_step(1, 0, 1, '0);
      tx_step(1, 0, 1, '0);
      tx_step(0, 0, 1, 2'b01);
      tx_step(1, 0, 1, '0);
      tx_step(1, 0, 1, '0);
      checks++;
      if (dut.cred_q[0] !== 4'd0)
         $display("FAIL exhaust_cred0 got %0d exp 0", dut.cred_q[0]);
      else passed++;
   endtask

   task automatic test_fire_and_return();
      tx_step(1, 0, 1, 2'b01);
      tx_step(1, 0, 1, 2'b01);
      checks++;
      if (dut.cred_q[0] !== 4'd1)
         $display("FAIL fire_ret_hold got %0d exp 1", dut.cred_q[0]);
      else passed++;
      tx_step(1, 0, 1, '0);
      tx_step(1, 0, 1, 2'b01);
      checks++;
      if (dut.cred_q[0] !== 4'd1)
         $display("FAIL ret_at_zero got %0d exp 1", dut.cred_q[0]);
      else passed++;
   endtask

   task automatic test_vc_lock();
      test_reset();
      tx_step(1, 1, 0, '0);
      tx_step(1, 0, 0, '0);
      tx_step(1, 0, 1, '0);
      checks++;
      if (dut.cred_q[1] !== 4'd5 || dut.cred_q[0] !== 4'd8)
         $display("FAIL vc_lock_creds got %0d/%0d exp 8/5",
                  dut.cred_q[0], dut.cred_q[1]);
      else passed++;
      tx_step(0, 0, 0, 2'b11);
      checks++;
      if (dut.cred_q[1] !== 4'd6 || dut.cred_q[0] !== 4'd8)
         $display("FAIL saturate got %0d/%0d exp 8/6",
                  dut.cred_q[0], dut.cred_q[1]);
      else passed++;
   endtask

   task automatic test_tx_random();
      for (int i = 0; i < 300; i++) begin
         logic [NV-1:0] r;
         r = '0;
         for (int k = 0; k < NV; k++) r[k] = ($urandom_range(0, 2) == 0);
         tx_step($urandom_range(0, 3) != 0, $urandom_range(0, NV - 1),
                 $urandom_range(0, 2) == 0, r);
      end
      for (int v = 0; v < NV; v++) begin
         checks++;
         if (dut.cred_q[v] !== 4'(mcred[v]))
            $display("FAIL rand_cred%0d got %0d exp %0d",
                     v, dut.cred_q[v], mcred[v]);
         else passed++;
      end
   endtask

   task automatic test_rx_interleave();
      for (int i = 0; i < 8; i++) rx_step(1, i % NV, 1);
      for (int i = 0; i < 3; i++) rx_step(0, 0, 1);
   endtask

   task automatic test_rx_overflow();
      for (int i = 0; i < RXD; i++) rx_step(1, 0, 0);
      rx_step(1, 0, 0);
`ifdef SWITCH_ENDPOINT_ERR_EN
      checks++;
      if (err_sticky[2] !== 1'b1)
         $display("FAIL err_rx_ovf got %b exp 1", err_sticky[2]);
      else passed++;
`endif
      rx_step(1, 0, 1);
      for (int i = 0; i < RXD + 1; i++) rx_step(0, 0, 1);
   endtask

   task automatic test_rx_random();
      for (int i = 0; i < 300; i++)
         rx_step($urandom_range(0, 1) == 1, $urandom_range(0, NV - 1),
                 $urandom_range(0, 2) != 0);
      for (int i = 0; i < 2 * RXD; i++) rx_step(0, 0, 1);
   endtask

   task automatic test_reset_mid_packet();
      test_reset();
      tx_step(1, 1, 0, '0);
      tx_step(1, 1, 0, '0);
      rx_step(1, 0, 0);
      test_reset();
      tx_step(1, 0, 0, '0);
      tx_step(1, 1, 1, '0);
      checks++;
      if (dut.cred_q[0] !== 4'd6 || dut.cred_q[1] !== 4'd8)
         $display("FAIL post_reset_creds got %0d/%0d exp 6/8",
                  dut.cred_q[0], dut.cred_q[1]);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_credit_exhaust();
      test_fire_and_return();
      test_vc_lock();
      test_tx_random();
      test_reset();
      test_rx_interleave();
      test_rx_overflow();
      test_rx_random();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
